mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between an instruction-fetch requester (IF) and a
//   data requester (D). D has fixed priority over IF. Each access occupies the
//   port for MEM_LAT cycles (BUSY) and is followed by a single DONE cycle
//   that pulses the owner's ack. A flush cancels an in-flight fetch. The
//   memory access still runs to completion, but its data and ack are dropped.
//
// Parameters
//   MEM_LAT       memory access latency in cycles, legal range 1..15
// Ports
//   clk_i, rst_i                     clock, synchronous active-high reset
//   if_req_i, if_addr_i              fetch request / address (held until ack)
//   if_rdata_o, if_ack_o, if_stall_o fetch data, completion pulse, stall
//   d_req_i, d_we_i, d_addr_i,       data request / store flag / address /
//   d_wdata_i                        store data (held until ack)
//   d_rdata_o, d_ack_o, d_stall_o    load data, completion pulse, stall
//   flush_i                          redirect, cancels an in-flight fetch
//   mem_en_o, mem_we_o, mem_addr_o,  shared memory request (BUSY only)
//   mem_wdata_o, mem_rdata_i         and read data (valid in last BUSY cycle)
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  input  logic        flush_i,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        if_stall_o,
  output logic        d_stall_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
  typedef enum logic [1:0] {OwnNone, OwnIf, OwnD} owner_e;

  localparam logic [3:0] LatInit = 4'(MEM_LAT - 1);

  state_e      state_q;
  owner_e      owner_q;
  logic [3:0]  cnt_q;
  logic        cancel_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      owner_q    <= OwnNone;
      cnt_q      <= 4'd0;
      cancel_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (d_req_i) begin
            owner_q  <= OwnD;
            addr_q   <= d_addr_i;
            we_q     <= d_we_i;
            wdata_q  <= d_wdata_i;
            cnt_q    <= LatInit;
            cancel_q <= 1'b0;
            state_q  <= StBusy;
          end else if (if_req_i) begin
            // Fetches never write; wdata_q keeps its old value.
            owner_q  <= OwnIf;
            addr_q   <= if_addr_i;
            we_q     <= 1'b0;
            cnt_q    <= LatInit;
            cancel_q <= 1'b0;
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          if (flush_i && (owner_q == OwnIf)) cancel_q <= 1'b1;
          if (cnt_q == 4'd0) begin
            // A flush in this very cycle must also block the capture.
            if ((owner_q == OwnIf) && !cancel_q && !flush_i) if_rdata_q <= mem_rdata_i;
            if ((owner_q == OwnD) && !we_q) d_rdata_q <= mem_rdata_i;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          owner_q <= OwnNone;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_en_o    = (state_q == StBusy);
  assign mem_we_o    = (state_q == StBusy) && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;

  // flush_i during DONE still kills the fetch ack in the same cycle.
  assign if_ack_o = (state_q == StDone) && (owner_q == OwnIf) && !cancel_q && !flush_i;
  assign d_ack_o  = (state_q == StDone) && (owner_q == OwnD);

  assign if_stall_o = if_req_i && !if_ack_o;
  assign d_stall_o  = d_req_i && !d_ack_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Bench for mem_port_arbiter: directed cycle tables at MEM_LAT=2, a reset
//   mid-transaction sequence, randomized traffic against a timeline model and
//   a back-to-back sweep on a second instance with MEM_LAT=1.
module tb_mem_port_arbiter;
  localparam int unsigned Lat = 2;

  localparam logic [31:0] R10  = 32'h2002_0005;
  localparam logic [31:0] R14  = 32'h3333_0014;
  localparam logic [31:0] R40  = 32'h1111_0040;
  localparam logic [31:0] Beef = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ifr, dr, dwe, fl;
  logic [31:0] ifa, da, dwd;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ack, d_ack, mem_en, mem_we, if_stall, d_stall;
  logic [31:0] mem_arr [64];

  assign mem_rdata = mem_arr[mem_addr[7:2]];

  mem_port_arbiter #(.MEM_LAT(Lat)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(ifr), .if_addr_i(ifa), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .d_req_i(dr), .d_we_i(dwe), .d_addr_i(da), .d_wdata_i(dwd),
    .d_rdata_o(d_rdata), .d_ack_o(d_ack), .flush_i(fl),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .if_stall_o(if_stall), .d_stall_o(d_stall)
  );

  // Second instance, MEM_LAT=1, memory returns a fixed function of the address.
  logic        rst1 = 1'b1, ifr1 = 1'b0, dr1 = 1'b0;
  logic [31:0] ifa1 = 32'h100, da1 = 32'h200;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_ack1, d_ack1, mem_en1, mem_we1, if_stall1, d_stall1;

  assign mem_rdata1 = mem_addr1 ^ 32'h5A5A_0000;

  mem_port_arbiter #(.MEM_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst1),
    .if_req_i(ifr1), .if_addr_i(ifa1), .if_rdata_o(if_rdata1), .if_ack_o(if_ack1),
    .d_req_i(dr1), .d_we_i(1'b0), .d_addr_i(da1), .d_wdata_i(32'h0),
    .d_rdata_o(d_rdata1), .d_ack_o(d_ack1), .flush_i(1'b0),
    .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1),
    .mem_wdata_o(mem_wdata1), .mem_rdata_i(mem_rdata1),
    .if_stall_o(if_stall1), .d_stall_o(d_stall1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Memory side of the port: stores land at the negedge of a BUSY cycle.
  task automatic mem_upd();
    if (mem_en === 1'b1 && mem_we === 1'b1) mem_arr[mem_addr[7:2]] = mem_wdata;
  endtask

  task automatic next_cycle();
    mem_upd();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ifr, dr, dwe, fl;
    logic [31:0] ifa, da, dwd;
    logic        e_ifack, e_dack, e_men, e_mwe, e_ifst, e_dst;
    logic [31:0] e_maddr, e_wdata, e_ifrd, e_drd;
  } vec_t;

  function automatic vec_t v(logic ifr_, logic [31:0] ifa_, logic dr_, logic dwe_,
                             logic [31:0] da_, logic [31:0] dwd_, logic fl_,
                             logic eia, logic eda, logic emen, logic emwe, logic eis,
                             logic eds, logic [31:0] ema, logic [31:0] ewd,
                             logic [31:0] eir, logic [31:0] edr);
    vec_t r;
    r.ifr = ifr_; r.ifa = ifa_; r.dr = dr_; r.dwe = dwe_; r.da = da_; r.dwd = dwd_;
    r.fl = fl_; r.e_ifack = eia; r.e_dack = eda; r.e_men = emen; r.e_mwe = emwe;
    r.e_ifst = eis; r.e_dst = eds; r.e_maddr = ema; r.e_wdata = ewd;
    r.e_ifrd = eir; r.e_drd = edr;
    return r;
  endfunction

  vec_t vq[$];

  // Timeline reference model for the random phase.
  bit          m_act, m_own_if, m_we, m_cancel;
  int          m_k;
  logic [31:0] m_addr, m_wd, m_ifrd, m_drd;
  logic [31:0] model_mem [64];
  bit          prev_ifack, prev_dack, prev_fl;

  initial begin
    for (int i = 0; i < 64; i++) mem_arr[i] = 32'hC000_0000 | 32'(i);
    mem_arr[2]  = 32'h0;
    mem_arr[4]  = R10;
    mem_arr[5]  = R14;
    mem_arr[16] = R40;

    // Fetch at 0x10.
    vq.push_back(v(1, 'h10, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 'h0, 0, 0, 0));
    vq.push_back(v(1, 'h10, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 'h10, 0, 0, 0));
    vq.push_back(v(1, 'h10, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 'h10, 0, 0, 0));
    vq.push_back(v(1, 'h10, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 'h10, 0, R10, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 'h10, 0, R10, 0));
    // Contention: D load 0x40 wins, then IF 0x14.
    vq.push_back(v(1, 'h14, 1, 0, 'h40, 0, 0, 0, 0, 0, 0, 1, 1, 'h10, 0, R10, 0));
    vq.push_back(v(1, 'h14, 1, 0, 'h40, 0, 0, 0, 0, 1, 0, 1, 1, 'h40, 0, R10, 0));
    vq.push_back(v(1, 'h14, 1, 0, 'h40, 0, 0, 0, 0, 1, 0, 1, 1, 'h40, 0, R10, 0));
    vq.push_back(v(1, 'h14, 1, 0, 'h40, 0, 0, 0, 1, 0, 0, 1, 0, 'h40, 0, R10, R40));
    vq.push_back(v(1, 'h14, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 'h40, 0, R10, R40));
    vq.push_back(v(1, 'h14, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 'h14, 0, R10, R40));
    vq.push_back(v(1, 'h14, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 'h14, 0, R10, R40));
    vq.push_back(v(1, 'h14, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 'h14, 0, R14, R40));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 'h14, 0, R14, R40));
    // Store DEADBEEF to 0x8.
    vq.push_back(v(0, 0, 1, 1, 'h8, Beef, 0, 0, 0, 0, 0, 0, 1, 'h14, 0, R14, R40));
    vq.push_back(v(0, 0, 1, 1, 'h8, Beef, 0, 0, 0, 1, 1, 0, 1, 'h8, Beef, R14, R40));
    vq.push_back(v(0, 0, 1, 1, 'h8, Beef, 0, 0, 0, 1, 1, 0, 1, 'h8, Beef, R14, R40));
    vq.push_back(v(0, 0, 1, 1, 'h8, Beef, 0, 0, 1, 0, 0, 0, 0, 'h8, 0, R14, R40));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 'h8, 0, R14, R40));
    // Fetch 0x8 flushed in BUSY: no ack, rdata untouched.
    vq.push_back(v(1, 'h8, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 'h8, 0, R14, R40));
    vq.push_back(v(1, 'h8, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1, 0, 'h8, 0, R14, R40));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 1,     0, 0, 1, 0, 0, 0, 'h8, 0, R14, R40));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 'h8, 0, R14, R40));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 'h8, 0, R14, R40));
    // Fetch 0x14 flushed in DONE: ack forced low.
    vq.push_back(v(1, 'h14, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 'h8, 0, R14, R40));
    vq.push_back(v(1, 'h14, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 'h14, 0, R14, R40));
    vq.push_back(v(1, 'h14, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 'h14, 0, R14, R40));
    vq.push_back(v(1, 'h14, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 'h14, 0, R14, R40));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 'h14, 0, R14, R40));
    // D load 0x10 with flush held high: unaffected.
    vq.push_back(v(0, 0, 1, 0, 'h10, 0, 1,  0, 0, 0, 0, 0, 1, 'h14, 0, R14, R40));
    vq.push_back(v(0, 0, 1, 0, 'h10, 0, 1,  0, 0, 1, 0, 0, 1, 'h10, 0, R14, R40));
    vq.push_back(v(0, 0, 1, 0, 'h10, 0, 1,  0, 0, 1, 0, 0, 1, 'h10, 0, R14, R40));
    vq.push_back(v(0, 0, 1, 0, 'h10, 0, 1,  0, 1, 0, 0, 0, 0, 'h10, 0, R14, R10));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 'h10, 0, R14, R10));
    // Flush in IDLE does not block the fetch grant.
    vq.push_back(v(1, 'h10, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 'h10, 0, R14, R10));
    vq.push_back(v(1, 'h10, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 'h10, 0, R14, R10));
    vq.push_back(v(1, 'h10, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 'h10, 0, R14, R10));
    vq.push_back(v(1, 'h10, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 'h10, 0, R10, R10));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 'h10, 0, R10, R10));
    // D request dropped after grant still completes.
    vq.push_back(v(0, 0, 1, 0, 'h40, 0, 0,  0, 0, 0, 0, 0, 1, 'h10, 0, R10, R10));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 'h40, 0, R10, R10));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 'h40, 0, R10, R10));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 'h40, 0, R10, R40));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 'h40, 0, R10, R40));

    // Reset
    rst = 1'b1; ifr = 1'b0; dr = 1'b0; dwe = 1'b0; fl = 1'b0;
    ifa = 32'h0; da = 32'h0; dwd = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_if_ack", 0, if_ack, 0);     chk("rst_d_ack", 0, d_ack, 0);
    chk("rst_if_stall", 0, if_stall, 0); chk("rst_d_stall", 0, d_stall, 0);
    chk("rst_mem_en", 0, mem_en, 0);     chk("rst_mem_we", 0, mem_we, 0);
    chk("rst_mem_addr", 0, mem_addr, 0); chk("rst_mem_wdata", 0, mem_wdata, 0);
    chk("rst_if_rdata", 0, if_rdata, 0); chk("rst_d_rdata", 0, d_rdata, 0);
    next_cycle();

    // Directed table
    foreach (vq[i]) begin
      ifr = vq[i].ifr; ifa = vq[i].ifa; dr = vq[i].dr; dwe = vq[i].dwe;
      da = vq[i].da; dwd = vq[i].dwd; fl = vq[i].fl;
      @(negedge clk);
      chk("if_ack", i, if_ack, vq[i].e_ifack);
      chk("d_ack", i, d_ack, vq[i].e_dack);
      chk("mem_en", i, mem_en, vq[i].e_men);
      chk("mem_we", i, mem_we, vq[i].e_mwe);
      chk("if_stall", i, if_stall, vq[i].e_ifst);
      chk("d_stall", i, d_stall, vq[i].e_dst);
      chk("mem_addr", i, mem_addr, vq[i].e_maddr);
      if (vq[i].e_mwe) chk("mem_wdata", i, mem_wdata, vq[i].e_wdata);
      chk("if_rdata", i, if_rdata, vq[i].e_ifrd);
      chk("d_rdata", i, d_rdata, vq[i].e_drd);
      next_cycle();
    end
    ifr = 1'b0; dr = 1'b0; fl = 1'b0; dwe = 1'b0;

    // Reset in the middle of a load, request held throughout
    dr = 1'b1; da = 32'h40;
    @(negedge clk); next_cycle();                      // cycle 0: grant
    @(negedge clk); chk("rmid_busy", 1, mem_en, 1); next_cycle();
    rst = 1'b1;
    @(negedge clk); chk("rmid_busy", 2, mem_en, 1); next_cycle();
    rst = 1'b0;
    @(negedge clk);                                    // cycle 3
    chk("rmid_d_ack", 3, d_ack, 0);       chk("rmid_if_ack", 3, if_ack, 0);
    chk("rmid_mem_en", 3, mem_en, 0);     chk("rmid_mem_we", 3, mem_we, 0);
    chk("rmid_mem_addr", 3, mem_addr, 0); chk("rmid_mem_wdata", 3, mem_wdata, 0);
    chk("rmid_if_rdata", 3, if_rdata, 0); chk("rmid_d_rdata", 3, d_rdata, 0);
    chk("rmid_d_stall", 3, d_stall, 1);
    next_cycle();
    @(negedge clk);
    chk("rmid_regrant", 4, mem_en, 1); chk("rmid_regrant_addr", 4, mem_addr, 32'h40);
    next_cycle();
    @(negedge clk); chk("rmid_no_early_ack", 5, d_ack, 0); next_cycle();
    @(negedge clk);
    chk("rmid_d_ack", 6, d_ack, 1); chk("rmid_d_rdata", 6, d_rdata, R40);
    next_cycle();
    dr = 1'b0;

    // Randomized traffic
    rst = 1'b1;
    @(negedge clk); next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) model_mem[i] = mem_arr[i];
    m_act = 0; m_k = 0; m_ifrd = 32'h0; m_drd = 32'h0; m_cancel = 0;
    prev_ifack = 0; prev_dack = 0; prev_fl = 0;
    for (int t = 0; t < 400; t++) begin
      bit e_men, e_done, e_ifack, e_dack, was_idle;
      if (!(ifr && !prev_ifack && !prev_fl)) begin
        ifr = 1'($urandom_range(0, 1));
        ifa = 32'($urandom_range(0, 63)) << 2;
      end
      if (!(dr && !prev_dack)) begin
        dr  = 1'($urandom_range(0, 1));
        dwe = 1'($urandom_range(0, 1));
        da  = 32'($urandom_range(0, 63)) << 2;
        dwd = $urandom;
      end
      fl = ($urandom_range(0, 5) == 0);

      e_men   = m_act && m_k >= 1 && m_k <= int'(Lat);
      e_done  = m_act && m_k == int'(Lat) + 1;
      e_ifack = e_done && m_own_if && !m_cancel && !fl;
      e_dack  = e_done && !m_own_if;
      if (e_done && m_own_if && !m_cancel) m_ifrd = model_mem[m_addr[7:2]];
      if (e_done && !m_own_if && !m_we) m_drd = model_mem[m_addr[7:2]];
      if (e_done && !m_own_if && m_we) model_mem[m_addr[7:2]] = m_wd;

      @(negedge clk);
      chk("rnd_if_ack", t, if_ack, e_ifack);
      chk("rnd_d_ack", t, d_ack, e_dack);
      chk("rnd_one_ack", t, if_ack & d_ack, 0);
      chk("rnd_mem_en", t, mem_en, e_men);
      chk("rnd_mem_we", t, mem_we, e_men && m_we);
      chk("rnd_if_stall", t, if_stall, ifr && !e_ifack);
      chk("rnd_d_stall", t, d_stall, dr && !e_dack);
      chk("rnd_if_rdata", t, if_rdata, m_ifrd);
      chk("rnd_d_rdata", t, d_rdata, m_drd);
      if (e_men) chk("rnd_mem_addr", t, mem_addr, m_addr);
      if (e_men && m_we) chk("rnd_mem_wdata", t, mem_wdata, m_wd);

      if (e_men && m_own_if && fl) m_cancel = 1;
      was_idle = !m_act;
      if (m_act) begin
        if (m_k == int'(Lat) + 1) m_act = 0;
        else m_k++;
      end
      if (was_idle && (dr || ifr)) begin
        m_act = 1; m_k = 1; m_cancel = 0;
        m_own_if = !dr;
        m_addr   = dr ? da : ifa;
        m_we     = dr && dwe;
        m_wd     = dwd;
      end
      prev_ifack = e_ifack; prev_dack = e_dack; prev_fl = fl;
      next_cycle();
    end
    ifr = 1'b0; dr = 1'b0; fl = 1'b0;

    // MEM_LAT=1 back-to-back sweep: D held for cycles 0-5, IF held throughout
    rst1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b0;
    ifr1 = 1'b1;
    for (int t = 0; t < 15; t++) begin
      dr1 = (t < 6);
      @(negedge clk);
      chk("lat1_d_ack", t, d_ack1, (t == 2 || t == 5));
      chk("lat1_if_ack", t, if_ack1, (t >= 8 && (t - 8) % 3 == 0));
      chk("lat1_one_ack", t, if_ack1 & d_ack1, 0);
      if (t >= 8 && (t - 8) % 3 == 0) chk("lat1_if_rdata", t, if_rdata1, 32'h5A5A_0100);
      @(posedge clk);
      #1;
    end
    ifr1 = 1'b0; dr1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
